dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WORDS, default 1024, meaning the number of valid data-memory words.
REQ-002 SHALL have parameter RR_INIT, default 0, meaning the port that holds priority after reset.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port req_valid, input, 2 bits: access request per port; port 0 is CPU load/store, port 1 is debug/DMA.
REQ-006 SHALL have port req_we, input, 2 bits: per-port write (1) or read (0).
REQ-007 SHALL have port req_addr, input, 2x32 bits: per-port word address.
REQ-008 SHALL have port req_wdata, input, 2x32 bits: per-port write data.
REQ-009 SHALL have port req_ready, output, 2 bits: request accepted this cycle, at most one bit set.
REQ-010 SHALL have port rsp_valid, output, 2 bits: one-cycle completion pulse per port.
REQ-011 SHALL have port rsp_rdata, output, 32 bits: read data, valid with rsp_valid.
REQ-012 SHALL have port rsp_err, output, 1 bit: out-of-range access flag, valid with rsp_valid.
REQ-013 SHALL have port DMEM_address, output, 32 bits: memory word address.
REQ-014 SHALL have port DMEM_data_in, output, 32 bits: memory write data.
REQ-015 SHALL have port DMEM_mem_write, output, 1 bit: memory write strobe.
REQ-016 SHALL have port DMEM_mem_read, output, 1 bit: memory read strobe.
REQ-017 SHALL have port DMEM_data_out, input, 32 bits: memory read data, combinational from the memory.

Function
REQ-018 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; one transaction is outstanding at a time.
REQ-019 In IDLE with any req_valid set, SHALL assert req_ready combinationally for the winner, latch its we/addr/wdata/port, and go to ACCESS next cycle.
REQ-020 Arbitration SHALL be round-robin: with both valid, the port not granted last wins; with one valid, it wins regardless of priority.
REQ-021 In IDLE with no req_valid, SHALL stay in IDLE and change no priority state.
REQ-022 In ACCESS, SHALL drive DMEM_address and DMEM_data_in from the latched request, assert exactly one of DMEM_mem_write/DMEM_mem_read for exactly that cycle, and register DMEM_data_out at the end of the cycle on reads.
REQ-023 Latched addr >= ADDR_WORDS SHALL assert no strobe in ACCESS, and SHALL give rsp_err=1 and rsp_rdata=0 in RESP.
REQ-024 In RESP, SHALL pulse rsp_valid for the latched port only; rsp_rdata holds read data on reads and 0 on writes; then go to IDLE.
REQ-025 Latency SHALL be: accepted on cycle N, strobe on N+1, rsp_valid on N+2; peak throughput is one transaction per 3 cycles.
REQ-026 req_ready SHALL be 0 in ACCESS and RESP; requesters hold req_valid and request fields until ready.
REQ-027 Outside ACCESS, both DMEM strobes SHALL be 0 and DMEM_address/DMEM_data_in SHALL hold their last values.

Reset
REQ-028 rst SHALL force: state IDLE, priority=RR_INIT, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, DMEM strobes=0, DMEM_address=0, DMEM_data_in=0.
REQ-029 rst asserted mid-transaction (ACCESS or RESP) SHALL abort it: no rsp_valid, and strobes low from the next edge.

Structure
REQ-030 State encoding (IDLE/ACCESS/RESP), port-index constants and the default ADDR_WORDS SHALL live in shared package mips_mem_pkg.
REQ-031 Round-robin selection SHALL be one sub-module rr_arb2 (2-bit req in, 2-bit one-hot grant, priority update on accept); the rest stays flat.

Verification
REQ-032 Reset, then port0 write addr 5 data 0xDEADBEEF, then port0 read addr 5 -> the write strobe occurs once, and the read gives rsp_valid[0] at N+2 with rdata 0xDEADBEEF, rsp_err=0.
REQ-033 Both ports requesting continuously after reset (RR_INIT=0) -> grants alternate 0,1,0,1; each accept is 3 cycles apart; no port is starved.
REQ-034 Port1 read addr 1024 -> no DMEM strobe; rsp_valid[1] with rsp_err=1, rdata=0.
REQ-035 rst pulsed in the ACCESS cycle of a port0 read -> no rsp_valid; next request is accepted from IDLE with priority RR_INIT.
REQ-036 Port1 alone issues 3 back-to-back writes -> each is granted to port1 with no idle-cycle penalty beyond the 3-cycle cadence, and a strobe-count checker confirms exactly 3 writes.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory access path: FSM states, port
// indices and the default memory depth.
package mips_mem_pkg;

    localparam int ADDR_W             = 32;
    localparam int DATA_W             = 32;
    localparam int N_PORTS            = 2;
    localparam int DEFAULT_ADDR_WORDS = 1024;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    function automatic logic [N_PORTS-1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: one-hot grant, priority passes to the
// other port whenever a grant is accepted.
module rr_arb2
    import mips_mem_pkg::*;
#(
    parameter int RR_INIT = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_PORTS-1:0] req,
    input  logic               accept,
    output logic [N_PORTS-1:0] grant
);

    logic prio;

    always_comb begin
        grant = '0;
        if (req == 2'b11) begin
            grant = port_onehot(prio);
        end else begin
            grant = req;
        end
    end

    // A single requester always wins, so only an accepted grant moves priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= (RR_INIT != 0);
        end else if (accept && (|grant)) begin
            prio <= grant[0];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the CPU load/store unit and a debug/DMA
// master; one transaction in flight, accept -> access -> response.
module dmem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_WORDS = DEFAULT_ADDR_WORDS,
    parameter int RR_INIT    = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_PORTS-1:0]              req_valid,
    input  logic [N_PORTS-1:0]              req_we,
    input  logic [N_PORTS-1:0][ADDR_W-1:0]  req_addr,
    input  logic [N_PORTS-1:0][DATA_W-1:0]  req_wdata,
    output logic [N_PORTS-1:0]              req_ready,
    output logic [N_PORTS-1:0]              rsp_valid,
    output logic [DATA_W-1:0]               rsp_rdata,
    output logic                            rsp_err,
    output logic [ADDR_W-1:0]               DMEM_address,
    output logic [DATA_W-1:0]               DMEM_data_in,
    output logic                            DMEM_mem_write,
    output logic                            DMEM_mem_read,
    input  logic [DATA_W-1:0]               DMEM_data_out
);

    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(ADDR_WORDS);

    state_t             state;
    state_t             state_nxt;
    logic [N_PORTS-1:0] grant;
    logic               accept;
    logic               win_port;
    logic               in_range;
    logic               access_en;
    logic               we_p1;
    logic               port_p1;

    rr_arb2 #(
        .RR_INIT (RR_INIT)
    ) u_rr_arb2 (
        .clk    (clk),
        .rst    (rst),
        .req    (req_valid),
        .accept (accept),
        .grant  (grant)
    );

    always_comb begin
        req_ready = '0;
        if ((state == ST_IDLE) && !rst) begin
            req_ready = grant;
        end
    end

    assign accept   = |req_ready;
    assign win_port = grant[1];

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept) state_nxt = ST_ACCESS;
            ST_ACCESS: state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Stage p1: accepted request latched; the address/data registers double as
    // the memory bus so they hold their value outside the access cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            DMEM_address <= '0;
            DMEM_data_in <= '0;
        end else if (accept) begin
            DMEM_address <= req_addr[win_port];
            DMEM_data_in <= req_wdata[win_port];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we_p1   <= req_we[win_port];
            port_p1 <= win_port;
        end
    end

    assign in_range       = (DMEM_address < ADDR_LIMIT);
    assign access_en      = (state == ST_ACCESS) && !rst;
    assign DMEM_mem_write = access_en && in_range && we_p1;
    assign DMEM_mem_read  = access_en && in_range && !we_p1;

    // Stage p2: response captured at the end of the access cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (state == ST_ACCESS) begin
            rsp_err   <= !in_range;
            rsp_rdata <= (in_range && !we_p1) ? DMEM_data_out : '0;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if ((state == ST_RESP) && !rst) begin
            rsp_valid = port_onehot(port_p1);
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural memory behind the
// DMEM port and strobe counters.
module tb_dmem_arbiter;

    logic              clk;
    logic              rst;
    logic [1:0]        req_valid;
    logic [1:0]        req_we;
    logic [1:0][31:0]  req_addr;
    logic [1:0][31:0]  req_wdata;
    logic [1:0]        req_ready;
    logic [1:0]        rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [31:0]       DMEM_address;
    logic [31:0]       DMEM_data_in;
    logic              DMEM_mem_write;
    logic              DMEM_mem_read;
    logic [31:0]       DMEM_data_out;

    logic [31:0] mem [1024];
    int          wr_cnt;
    int          rd_cnt;
    int          checks;
    int          errors;

    dmem_arbiter #(
        .ADDR_WORDS (1024),
        .RR_INIT    (0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .DMEM_address   (DMEM_address),
        .DMEM_data_in   (DMEM_data_in),
        .DMEM_mem_write (DMEM_mem_write),
        .DMEM_mem_read  (DMEM_mem_read),
        .DMEM_data_out  (DMEM_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign DMEM_data_out = mem[DMEM_address[9:0]];

    always @(posedge clk) begin
        if (DMEM_mem_write) mem[DMEM_address[9:0]] <= DMEM_data_in;
    end

    initial begin
        wr_cnt = 0;
        rd_cnt = 0;
    end

    always @(posedge clk) begin
        if (DMEM_mem_write) wr_cnt <= wr_cnt + 1;
        if (DMEM_mem_read)  rd_cnt <= rd_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Single transaction on one port, started at a negedge with the DUT idle.
    task automatic txn(input string tag, input int p, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
        logic [1:0] oh;
        oh = (p == 1) ? 2'b10 : 2'b01;
        req_valid    = oh;
        req_we[p]    = we;
        req_addr[p]  = addr;
        req_wdata[p] = wdata;
        #1;
        check({tag, " ready"}, 32'(req_ready), 32'(oh));
        @(negedge clk);
        req_valid = 2'b00;
        check({tag, " wr strobe"}, 32'(DMEM_mem_write), 32'(we && !exp_err));
        check({tag, " rd strobe"}, 32'(DMEM_mem_read), 32'(!we && !exp_err));
        check({tag, " address"}, DMEM_address, addr);
        check({tag, " data_in"}, DMEM_data_in, wdata);
        check({tag, " ready busy"}, 32'(req_ready), 32'd0);
        @(negedge clk);
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'(oh));
        check({tag, " rdata"}, rsp_rdata, exp_rdata);
        check({tag, " err"}, 32'(rsp_err), 32'(exp_err));
        @(negedge clk);
        check({tag, " rsp idle"}, 32'(rsp_valid), 32'd0);
        check({tag, " strobes idle"}, 32'({DMEM_mem_write, DMEM_mem_read}), 32'd0);
        check({tag, " addr hold"}, DMEM_address, addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wr0;
        int rd0;
        logic [1:0] exp_g;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        req_valid = 2'b11;
        req_we    = 2'b00;
        req_addr  = '0;
        req_wdata = '0;

        // Reset state, with both requests pending so ready gating is exercised.
        @(negedge clk);
        @(negedge clk);
        check("rst ready", 32'(req_ready), 32'd0);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rdata", rsp_rdata, 32'd0);
        check("rst err", 32'(rsp_err), 32'd0);
        check("rst strobes", 32'({DMEM_mem_write, DMEM_mem_read}), 32'd0);
        check("rst address", DMEM_address, 32'd0);
        check("rst data_in", DMEM_data_in, 32'd0);
        rst       = 1'b0;
        req_valid = 2'b00;
        @(negedge clk);

        // Write then read back through the CPU port.
        wr0 = wr_cnt;
        txn("p0 wr5", 0, 1'b1, 32'd5, 32'hDEADBEEF, 32'd0, 1'b0);
        check("p0 wr count", 32'(wr_cnt - wr0), 32'd1);
        txn("p0 rd5", 0, 1'b0, 32'd5, 32'h1234_5678, 32'hDEADBEEF, 1'b0);

        // Out-of-range read on the debug port never reaches the memory.
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        txn("p1 rd1024", 1, 1'b0, 32'd1024, 32'h0, 32'd0, 1'b1);
        check("oor no strobes", 32'((wr_cnt - wr0) + (rd_cnt - rd0)), 32'd0);
        txn("p1 wr1023", 1, 1'b1, 32'd1023, 32'hA5A5_0001, 32'd0, 1'b0);
        txn("p0 rd1023", 0, 1'b0, 32'd1023, 32'h0, 32'hA5A5_0001, 1'b0);

        // Both ports requesting continuously: grants alternate every 3 cycles.
        do_reset();
        req_we       = 2'b00;
        req_addr[0]  = 32'd5;
        req_addr[1]  = 32'd1023;
        req_valid    = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            check($sformatf("rr grant %0d", i), 32'(req_ready), 32'(exp_g));
            @(negedge clk);
            check($sformatf("rr busy %0d", i), 32'(req_ready), 32'd0);
            @(negedge clk);
            check($sformatf("rr rsp %0d", i), 32'(rsp_valid), 32'(exp_g));
            check($sformatf("rr rdata %0d", i), rsp_rdata,
                  (i % 2 == 0) ? 32'hDEADBEEF : 32'hA5A5_0001);
            @(negedge clk);
        end
        req_valid = 2'b00;
        @(negedge clk);

        // Reset during ACCESS aborts the read and restores RR_INIT priority.
        txn("pre-abort p0", 0, 1'b1, 32'd7, 32'h0000_0007, 32'd0, 1'b0);
        req_valid   = 2'b01;
        req_we[0]   = 1'b0;
        req_addr[0] = 32'd5;
        #1;
        check("abort accept", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        check("abort no rsp", 32'(rsp_valid), 32'd0);
        check("abort strobes", 32'({DMEM_mem_write, DMEM_mem_read}), 32'd0);
        @(negedge clk);
        check("abort no rsp later", 32'(rsp_valid), 32'd0);
        req_valid = 2'b11;
        #1;
        check("abort prio reinit", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        check("abort next rsp", 32'(rsp_valid), 32'd1);
        @(negedge clk);

        // Debug port alone: three back-to-back writes at full cadence.
        wr0          = wr_cnt;
        req_we[1]    = 1'b1;
        req_addr[1]  = 32'd20;
        req_wdata[1] = 32'hC0DE_0000;
        req_valid    = 2'b10;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("b2b grant %0d", i), 32'(req_ready), 32'd2);
            @(negedge clk);
            check($sformatf("b2b addr %0d", i), DMEM_address, 32'(20 + i));
            check($sformatf("b2b wr %0d", i), 32'(DMEM_mem_write), 32'd1);
            req_addr[1]  = 32'(21 + i);
            req_wdata[1] = 32'hC0DE_0000 + 32'(i + 1);
            @(negedge clk);
            check($sformatf("b2b rsp %0d", i), 32'(rsp_valid), 32'd2);
            @(negedge clk);
        end
        req_valid = 2'b00;
        @(negedge clk);
        check("b2b wr count", 32'(wr_cnt - wr0), 32'd3);
        txn("b2b readback", 0, 1'b0, 32'd21, 32'h0, 32'hC0DE_0001, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
